axi_tlb_lookup_arb: RTL and testbench

Shares a single TLB lookup engine between the write-address (AW) and read-address (AR) translation requesters of the AXI TLB. It arbitrates lookup requests round-robin and records the issuing requester of each in-flight lookup in an order FIFO. In-order lookup results are routed back to the requester that issued them. The block sits between the AW/AR forks of the TLB and one lookup port, so a single-ported translation structure can serve both channels.

---
 rtl/axi_tlb_lookup_arb.sv | 175 +++++++++++++++++
 tb/tb_axi_tlb_lookup_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_tlb_lookup_arb.sv
// axi_tlb_lookup_arb
// Shares one TLB lookup engine between the AW (wr) and AR (rd) translation
// requesters. Requests are arbitrated round-robin, the issuing requester of
// each outstanding lookup is remembered in a small order FIFO, and in-order
// results are steered back to whoever issued them.
//
// Optional feature: define AXI_TLB_LOOKUP_ARB_PERF_CNT_EN to build the
// saturating per-requester grant counters. Without it the counter outputs
// are tied to zero and no counter registers exist.

module axi_tlb_lookup_arb #(
  parameter int unsigned AddrWidth   = 0,
  parameter int unsigned MaxInflight = 4,
  parameter int unsigned CntWidth    = 16,
  parameter type         res_t       = logic,
  // Address ports are never narrower than one bit, even for a zero default.
  localparam int unsigned AW = (AddrWidth < 1) ? 1 : AddrWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic [AW-1:0]       wr_req_addr_i,
  input  logic                wr_req_valid_i,
  output logic                wr_req_ready_o,
  output res_t                wr_res_o,
  output logic                wr_res_valid_o,
  input  logic                wr_res_ready_i,

  input  logic [AW-1:0]       rd_req_addr_i,
  input  logic                rd_req_valid_i,
  output logic                rd_req_ready_o,
  output res_t                rd_res_o,
  output logic                rd_res_valid_o,
  input  logic                rd_res_ready_i,

  output logic [AW-1:0]       lkp_req_addr_o,
  output logic                lkp_req_valid_o,
  input  logic                lkp_req_ready_i,
  input  res_t                lkp_res_i,
  input  logic                lkp_res_valid_i,
  output logic                lkp_res_ready_o,

  output logic [CntWidth-1:0] wr_grant_cnt_o,
  output logic [CntWidth-1:0] rd_grant_cnt_o
);

  localparam int unsigned PtrW  = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
  localparam int unsigned CntQW = $clog2(MaxInflight + 1);

  localparam logic [CntQW-1:0] MaxCnt  = CntQW'(MaxInflight);
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(MaxInflight - 1);

  // Requester IDs: 0 = wr, 1 = rd.
  logic                   prio_q;
  logic                   lock_q;
  logic                   lock_sel_q;
  logic [MaxInflight-1:0] fifo_q;
  logic [PtrW-1:0]        wptr_q;
  logic [PtrW-1:0]        rptr_q;
  logic [CntQW-1:0]       cnt_q;

  logic sel;
  logic sel_valid;
  logic eligible;
  logic req_hs;
  logic fifo_empty;
  logic head;
  logic res_hs;

  // Slot availability uses the registered count, so a same-cycle pop never frees a slot.
  assign eligible   = (cnt_q < MaxCnt);
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rptr_q];

  // A held request keeps its requester; otherwise a lone requester wins, and ties go to prio_q.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (wr_req_valid_i && !rd_req_valid_i) begin
      sel = 1'b0;
    end else if (rd_req_valid_i && !wr_req_valid_i) begin
      sel = 1'b1;
    end else if (wr_req_valid_i && rd_req_valid_i) begin
      sel = prio_q;
    end
  end

  assign sel_valid       = sel ? rd_req_valid_i : wr_req_valid_i;
  assign lkp_req_valid_o = sel_valid & eligible;
  assign lkp_req_addr_o  = sel ? rd_req_addr_i : wr_req_addr_i;
  assign wr_req_ready_o  = ~sel & lkp_req_ready_i & eligible;
  assign rd_req_ready_o  =  sel & lkp_req_ready_i & eligible;
  assign req_hs          = lkp_req_valid_o & lkp_req_ready_i;

  // Results are steered by the FIFO head; an empty FIFO never accepts a result.
  assign wr_res_o        = lkp_res_i;
  assign rd_res_o        = lkp_res_i;
  assign wr_res_valid_o  = lkp_res_valid_i & ~fifo_empty & ~head;
  assign rd_res_valid_o  = lkp_res_valid_i & ~fifo_empty &  head;
  assign lkp_res_ready_o = (head ? rd_res_ready_i : wr_res_ready_i) & ~fifo_empty;
  assign res_hs          = lkp_res_valid_i & lkp_res_ready_o;

  // Round-robin priority flips away from whoever was just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (req_hs) begin
      prio_q <= ~sel;
    end
  end

  // Hold the selection while the engine stalls so valid and address stay stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else if (req_hs) begin
      lock_q     <= 1'b0;
    end else if (lkp_req_valid_o && !lkp_req_ready_i) begin
      lock_q     <= 1'b1;
      lock_sel_q <= sel;
    end
  end

  // Order FIFO: push the granted ID, pop on result handshake, pointers wrap at MaxInflight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (req_hs) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      end
      if (res_hs) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
      end
      case ({req_hs, res_hs})
        2'b10:   cnt_q <= cnt_q + CntQW'(1);
        2'b01:   cnt_q <= cnt_q - CntQW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef AXI_TLB_LOOKUP_ARB_PERF_CNT_EN
  logic [CntWidth-1:0] wr_cnt_q;
  logic [CntWidth-1:0] rd_cnt_q;

  // Per-requester grant counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (req_hs) begin
      if (!sel && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + CntWidth'(1);
      end
      if (sel && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + CntWidth'(1);
      end
    end
  end

  assign wr_grant_cnt_o = wr_cnt_q;
  assign rd_grant_cnt_o = rd_cnt_q;
`else
  assign wr_grant_cnt_o = '0;
  assign rd_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_tlb_lookup_arb.sv
// Directed testbench for axi_tlb_lookup_arb: reset values, round-robin
// alternation, stall lock, full order FIFO, result backpressure, reset
// while lookups are outstanding, and grant counter behaviour (including a
// second instance with 2-bit counters for saturation).

module tb_axi_tlb_lookup_arb;

`ifdef AXI_TLB_LOOKUP_ARB_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef logic [7:0] res_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] wr_req_addr, rd_req_addr;
  logic        wr_req_valid, rd_req_valid;
  logic        wr_req_ready, rd_req_ready;
  res_t        wr_res, rd_res;
  logic        wr_res_valid, rd_res_valid;
  logic        wr_res_ready, rd_res_ready;
  logic [31:0] lkp_req_addr;
  logic        lkp_req_valid, lkp_req_ready;
  res_t        lkp_res;
  logic        lkp_res_valid, lkp_res_ready;
  logic [15:0] wr_grant_cnt, rd_grant_cnt;

  logic [31:0] s_lkp_req_addr;
  logic        s_wr_req_ready, s_rd_req_ready, s_wr_res_valid, s_rd_res_valid;
  logic        s_lkp_req_valid, s_lkp_res_ready;
  res_t        s_wr_res, s_rd_res;
  logic [1:0]  s_wr_grant_cnt, s_rd_grant_cnt;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  axi_tlb_lookup_arb #(
    .AddrWidth(32), .MaxInflight(4), .CntWidth(16), .res_t(res_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_req_addr_i(wr_req_addr), .wr_req_valid_i(wr_req_valid), .wr_req_ready_o(wr_req_ready),
    .wr_res_o(wr_res), .wr_res_valid_o(wr_res_valid), .wr_res_ready_i(wr_res_ready),
    .rd_req_addr_i(rd_req_addr), .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready),
    .rd_res_o(rd_res), .rd_res_valid_o(rd_res_valid), .rd_res_ready_i(rd_res_ready),
    .lkp_req_addr_o(lkp_req_addr), .lkp_req_valid_o(lkp_req_valid), .lkp_req_ready_i(lkp_req_ready),
    .lkp_res_i(lkp_res), .lkp_res_valid_i(lkp_res_valid), .lkp_res_ready_o(lkp_res_ready),
    .wr_grant_cnt_o(wr_grant_cnt), .rd_grant_cnt_o(rd_grant_cnt)
  );

  axi_tlb_lookup_arb #(
    .AddrWidth(32), .MaxInflight(4), .CntWidth(2), .res_t(res_t)
  ) dut_sat (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_req_addr_i(wr_req_addr), .wr_req_valid_i(wr_req_valid), .wr_req_ready_o(s_wr_req_ready),
    .wr_res_o(s_wr_res), .wr_res_valid_o(s_wr_res_valid), .wr_res_ready_i(wr_res_ready),
    .rd_req_addr_i(rd_req_addr), .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(s_rd_req_ready),
    .rd_res_o(s_rd_res), .rd_res_valid_o(s_rd_res_valid), .rd_res_ready_i(rd_res_ready),
    .lkp_req_addr_o(s_lkp_req_addr), .lkp_req_valid_o(s_lkp_req_valid), .lkp_req_ready_i(lkp_req_ready),
    .lkp_res_i(lkp_res), .lkp_res_valid_i(lkp_res_valid), .lkp_res_ready_o(s_lkp_res_ready),
    .wr_grant_cnt_o(s_wr_grant_cnt), .rd_grant_cnt_o(s_rd_grant_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives all DUT inputs, then lets the combinational paths settle.
  task automatic applyStimulus(input logic wv, input logic [31:0] wa, input logic rv,
                               input logic [31:0] ra, input logic lrdy, input logic resv,
                               input res_t resd, input logic wrr, input logic rdr);
    wr_req_valid  = wv;
    wr_req_addr   = wa;
    rd_req_valid  = rv;
    rd_req_addr   = ra;
    lkp_req_ready = lrdy;
    lkp_res_valid = resv;
    lkp_res       = resd;
    wr_res_ready  = wrr;
    rd_res_ready  = rdr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(0, 32'hAAAA, 0, 32'hBBBB, 0, 1, 8'h11, 1, 1);
    checkOutput("rst_req_valid", lkp_req_valid, 0);
    checkOutput("rst_wr_req_ready", wr_req_ready, 0);
    checkOutput("rst_rd_req_ready", rd_req_ready, 0);
    checkOutput("rst_lkp_res_ready", lkp_res_ready, 0);
    checkOutput("rst_wr_res_valid", wr_res_valid, 0);
    checkOutput("rst_rd_res_valid", rd_res_valid, 0);
    checkOutput("rst_addr_follows_wr", lkp_req_addr, 32'hAAAA);
    checkOutput("rst_wr_cnt", wr_grant_cnt, 0);
    checkOutput("rst_rd_cnt", rd_grant_cnt, 0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Alternation: both requesters valid, engine always ready, 1-cycle result return.
    for (int i = 0; i <= 8; i++) begin
      applyStimulus(i < 8, 32'hA000 + i, i < 8, 32'hB000 + i, 1, i > 0, res_t'(i), 1, 1);
      checkOutput("alt_req_valid", lkp_req_valid, (i < 8) ? 1 : 0);
      if (i < 8) begin
        checkOutput("alt_addr", lkp_req_addr, (i % 2 == 0) ? 32'hA000 + i : 32'hB000 + i);
        checkOutput("alt_wr_req_ready", wr_req_ready, (i % 2 == 0) ? 1 : 0);
        checkOutput("alt_rd_req_ready", rd_req_ready, (i % 2 == 1) ? 1 : 0);
      end
      if (i > 0) begin
        checkOutput("alt_wr_res_valid", wr_res_valid, ((i - 1) % 2 == 0) ? 1 : 0);
        checkOutput("alt_rd_res_valid", rd_res_valid, ((i - 1) % 2 == 1) ? 1 : 0);
        checkOutput("alt_res_data", {24'h0, ((i - 1) % 2 == 0) ? wr_res : rd_res}, i);
      end
      tick();
    end
    checkOutput("alt_wr_cnt", wr_grant_cnt, PerfEn ? 4 : 0);
    checkOutput("alt_rd_cnt", rd_grant_cnt, PerfEn ? 4 : 0);
    checkOutput("sat_wr_cnt", s_wr_grant_cnt, PerfEn ? 3 : 0);
    checkOutput("sat_rd_cnt", s_rd_grant_cnt, PerfEn ? 3 : 0);

    // Stall lock: rd alone at 0x1000 while the engine stalls, wr joins mid-stall.
    applyStimulus(0, 32'h2000, 1, 32'h1000, 0, 0, 8'h00, 1, 1);
    checkOutput("stall_valid", lkp_req_valid, 1);
    checkOutput("stall_addr0", lkp_req_addr, 32'h1000);
    checkOutput("stall_rd_ready0", rd_req_ready, 0);
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 32'h2000, 1, 32'h1000, 0, 0, 8'h00, 1, 1);
      checkOutput("stall_addr_held", lkp_req_addr, 32'h1000);
      checkOutput("stall_wr_ready", wr_req_ready, 0);
      tick();
    end
    applyStimulus(1, 32'h2000, 1, 32'h1000, 1, 0, 8'h00, 1, 1);
    checkOutput("stall_hs_addr", lkp_req_addr, 32'h1000);
    checkOutput("stall_hs_rd_ready", rd_req_ready, 1);
    checkOutput("stall_hs_wr_ready", wr_req_ready, 0);
    tick();
    applyStimulus(1, 32'h2000, 1, 32'h1004, 1, 0, 8'h00, 1, 1);
    checkOutput("stall_next_addr", lkp_req_addr, 32'h2000);
    checkOutput("stall_next_wr_ready", wr_req_ready, 1);
    checkOutput("stall_next_rd_ready", rd_req_ready, 0);
    tick();

    // Full FIFO: two more wr grants fill the four slots (rd, wr, wr, wr).
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 32'h3000 + c, 0, 32'h0, 1, 0, 8'h00, 1, 1);
      checkOutput("fill_wr_ready", wr_req_ready, 1);
      tick();
    end
    applyStimulus(1, 32'h3010, 0, 32'h0, 1, 0, 8'h00, 1, 1);
    checkOutput("full_req_valid", lkp_req_valid, 0);
    checkOutput("full_wr_ready", wr_req_ready, 0);
    tick();
    applyStimulus(1, 32'h3010, 0, 32'h0, 1, 1, 8'h55, 1, 1);
    checkOutput("full_pop_req_valid", lkp_req_valid, 0);
    checkOutput("full_pop_rd_res_valid", rd_res_valid, 1);
    checkOutput("full_pop_wr_res_valid", wr_res_valid, 0);
    checkOutput("full_pop_res_ready", lkp_res_ready, 1);
    tick();
    applyStimulus(1, 32'h3010, 0, 32'h0, 1, 0, 8'h00, 1, 1);
    checkOutput("after_pop_req_valid", lkp_req_valid, 1);
    checkOutput("after_pop_wr_ready", wr_req_ready, 1);
    tick();

    // Result backpressure: head is wr and wr is not ready, rd is ready.
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 8'h66, 0, 1);
    checkOutput("bp_res_ready", lkp_res_ready, 0);
    checkOutput("bp_rd_res_valid", rd_res_valid, 0);
    checkOutput("bp_wr_res_valid", wr_res_valid, 1);
    checkOutput("bp_wr_res_data", wr_res, 8'h66);
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 8'h67, 1, 1);
      checkOutput("bp_release_res_ready", lkp_res_ready, 1);
      tick();
    end

    // Reset with two lookups outstanding.
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 8'h00, 1, 1);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_wr_cnt", wr_grant_cnt, 0);
    checkOutput("midrst_rd_cnt", rd_grant_cnt, 0);
    checkOutput("midrst_res_ready", lkp_res_ready, 0);
    tick();
    rst_ni = 1'b1;
    applyStimulus(0, 32'h0, 0, 32'h0, 1, 1, 8'h77, 1, 1);
    checkOutput("postrst_res_ready", lkp_res_ready, 0);
    checkOutput("postrst_wr_res_valid", wr_res_valid, 0);
    checkOutput("postrst_rd_res_valid", rd_res_valid, 0);
    tick();
    applyStimulus(1, 32'h4000, 1, 32'h5000, 1, 0, 8'h00, 1, 1);
    checkOutput("postrst_prio_addr", lkp_req_addr, 32'h4000);
    checkOutput("postrst_wr_ready", wr_req_ready, 1);
    tick();
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 8'h88, 1, 1);
    checkOutput("postrst_wr_res_valid2", wr_res_valid, 1);
    checkOutput("postrst_res_ready2", lkp_res_ready, 1);
    checkOutput("postrst_wr_cnt", wr_grant_cnt, PerfEn ? 1 : 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
